mac_acc_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for CNN convolution and fully-connected dot products. It is the next generation of the team's single-shot `lpm_mult` multiplier, generalised in operand widths, signedness and pipeline depth. It adds:
- framed accumulation over a variable-length kernel window;
- bias preload from `sumin`;
- saturation with a sticky overflow flag;
- valid tracking through the pipe.

It sits between the line-buffer/weight-ROM readers and the activation/requantisation stage.

---
 rtl/mac_acc_pipe.sv | 96 +++++++++
 tb/tb_mac_acc_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_pipe.sv
// Pipelined multiply-accumulate for dot products: framed accumulation with bias preload,
// optional saturation with a sticky overflow flag, and valid/first/last tags carried alongside the data.
module mac_acc_pipe #(
    parameter int WIDTH_A    = 8,
    parameter int WIDTH_B    = 8,
    parameter int WIDTH_S    = 16,
    parameter int ACC_W      = 32,
    parameter int SIGNED     = 1,
    parameter int MUL_STAGES = 2,
    parameter int SATURATE   = 1
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic               clken,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [WIDTH_A-1:0] dataa,
    input  logic [WIDTH_B-1:0] datab,
    input  logic [WIDTH_S-1:0] sumin,
    output logic [ACC_W-1:0]   result,
    output logic               out_valid,
    output logic               overflow
);
    localparam int PW  = WIDTH_A + WIDTH_B;
    localparam int M   = MUL_STAGES;
    localparam bit SGN = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    // Stage 0 holds the raw operands; stages 1..M hold the product.
    // vld_pipe/last_pipe run one slot further so slot M+1 tags the accumulator.
    logic [WIDTH_A-1:0]      a_q;
    logic [WIDTH_B-1:0]      b_q;
    logic [M+1:0]            vld_pipe;
    logic [M+1:0]            last_pipe;
    logic [M:0]              first_pipe;
    logic [M:0][WIDTH_S-1:0] bias_pipe;
    logic [M:1][PW-1:0]      prod_pipe;

    logic [PW-1:0]    a_x, b_x, prod;
    logic [ACC_W:0]   p_ext, s_ext, a_ext, sum;
    logic [ACC_W-1:0] acc, acc_next, sat_val;
    logic             sticky, ovf;

    // Extending both operands to the full product width makes one modulo-2^PW
    // multiply correct for signed and unsigned alike.
    assign a_x  = {{WIDTH_B{SGN & a_q[WIDTH_A-1]}}, a_q};
    assign b_x  = {{WIDTH_A{SGN & b_q[WIDTH_B-1]}}, b_q};
    assign prod = a_x * b_x;

    assign p_ext = {{(ACC_W+1-PW){SGN & prod_pipe[M][PW-1]}}, prod_pipe[M]};
    assign s_ext = {{(ACC_W+1-WIDTH_S){SGN & bias_pipe[M][WIDTH_S-1]}}, bias_pipe[M]};
    assign a_ext = {SGN & acc[ACC_W-1], acc};
    assign sum   = (first_pipe[M] ? s_ext : a_ext) + p_ext;

    assign ovf      = SGN ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    assign sat_val  = SGN ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : {ACC_W{1'b1}};
    assign acc_next = (SAT && ovf) ? sat_val : sum[ACC_W-1:0];

    // Data path carries no reset; only the tags decide what is live.
    always_ff @(posedge clock) begin
        if (clken) begin
            a_q          <= dataa;
            b_q          <= datab;
            bias_pipe    <= {bias_pipe[M-1:0], sumin};
            prod_pipe[1] <= prod;
            for (int i = 2; i <= M; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            result     <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else if (clken) begin
            vld_pipe   <= {vld_pipe[M:0], in_valid};
            first_pipe <= {first_pipe[M-1:0], in_valid & in_first};
            last_pipe  <= {last_pipe[M:0], in_valid & in_last};
            if (vld_pipe[M]) begin
                acc    <= acc_next;
                sticky <= first_pipe[M] ? ovf : (sticky | ovf);
            end
            out_valid <= vld_pipe[M+1] & last_pipe[M+1];
            if (vld_pipe[M+1] && last_pipe[M+1]) begin
                result   <= acc;
                overflow <= sticky;
            end
        end
    end
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: four configurations share one stimulus stream; directed vectors
// plus random frames scored against an integer model of the framed dot product.
module tb_mac_acc_pipe;
    logic        clock = 1'b0;
    logic        aclr, clken, in_valid, in_first, in_last;
    logic [7:0]  dataa, datab;
    logic [15:0] sumin;
    logic [31:0] res0, res3;
    logic [15:0] res1, res2;
    logic [3:0]  ov_v, ovf_v;
    logic [31:0] res_all [4];

    always #5 clock = ~clock;

    // d0: signed/32/sat, d1: signed/16/sat, d2: signed/16/wrap, d3: unsigned/32/sat with 3 mul stages
    mac_acc_pipe dut0 (.clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .dataa(dataa), .datab(datab), .sumin(sumin), .result(res0), .out_valid(ov_v[0]), .overflow(ovf_v[0]));
    mac_acc_pipe #(.ACC_W(16), .SATURATE(1)) dut1 (.clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .dataa(dataa), .datab(datab), .sumin(sumin), .result(res1), .out_valid(ov_v[1]), .overflow(ovf_v[1]));
    mac_acc_pipe #(.ACC_W(16), .SATURATE(0)) dut2 (.clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .dataa(dataa), .datab(datab), .sumin(sumin), .result(res2), .out_valid(ov_v[2]), .overflow(ovf_v[2]));
    mac_acc_pipe #(.SIGNED(0), .MUL_STAGES(3)) dut3 (.clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .dataa(dataa), .datab(datab), .sumin(sumin), .result(res3), .out_valid(ov_v[3]), .overflow(ovf_v[3]));

    assign res_all[0] = res0;
    assign res_all[1] = {16'h0, res1};
    assign res_all[2] = {16'h0, res2};
    assign res_all[3] = res3;

    typedef struct { longint v; bit o; } exp_t;
    typedef struct { int d; int s; int a; int b; longint res; bit ovf; } vec_t;

    exp_t   mq [4][$];
    longint m_acc [4];
    bit     m_st [4];
    int     nvec = 0;
    int     nmis = 0;
    int     cmode = 0;

    function automatic int cw(input int d);
        return (d == 1 || d == 2) ? 16 : 32;
    endfunction
    function automatic bit csg(input int d);
        return d != 3;
    endfunction
    function automatic bit csat(input int d);
        return d != 2;
    endfunction

    function automatic longint sres(input int d);
        case (d)
            0:       return longint'($signed(res0));
            1:       return longint'($signed(res1));
            2:       return longint'($signed(res2));
            default: return longint'(res3);
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range check and clamp/wrap.
    function automatic void model_beat(input int d, input bit f, input bit l,
                                       input logic [7:0] a, input logic [7:0] b, input logic [15:0] s);
        longint one, span, hi, lo, av, bv, sv, sum, v;
        bit ov;
        one  = 1;
        span = one << cw(d);
        hi   = csg(d) ? (one << (cw(d) - 1)) - 1 : span - 1;
        lo   = csg(d) ? -(one << (cw(d) - 1)) : 0;
        av   = csg(d) ? longint'($signed(a)) : longint'(a);
        bv   = csg(d) ? longint'($signed(b)) : longint'(b);
        sv   = csg(d) ? longint'($signed(s)) : longint'(s);
        sum  = (f ? sv : m_acc[d]) + av * bv;
        ov   = (sum > hi) || (sum < lo);
        v    = sum;
        if (ov) begin
            if (csat(d)) v = (sum > hi) ? hi : lo;
            else begin
                v = sum % span;
                if (v < 0) v += span;
                if (v > hi) v -= span;
            end
        end
        m_acc[d] = v;
        m_st[d]  = f ? ov : (m_st[d] | ov);
        if (l) mq[d].push_back('{v, m_st[d]});
    endfunction

    // Scoreboard: feed accepted beats to the model, check every fresh out_valid pulse.
    always @(posedge clock) begin : mon
        bit     en;
        exp_t   e;
        longint msk;
        en = clken && !aclr;
        if (aclr) begin
            for (int d = 0; d < 4; d++) mq[d].delete();
        end else if (clken && in_valid) begin
            for (int d = 0; d < 4; d++) model_beat(d, in_first, in_last, dataa, datab, sumin);
        end
        #1;
        if (en) begin
            for (int d = 0; d < 4; d++) begin
                if (ov_v[d]) begin
                    if (mq[d].size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL sb_d%0d: unexpected out_valid, result %0d, expected none", d, res_all[d]);
                    end else begin
                        e   = mq[d].pop_front();
                        msk = (longint'(1) << cw(d)) - 1;
                        chk($sformatf("sb_d%0d_res", d), longint'(res_all[d]), e.v & msk);
                        chk($sformatf("sb_d%0d_ovf", d), longint'(ovf_v[d]), longint'(e.o));
                    end
                end
            end
        end
    end

    task automatic next_en();
        case (cmode)
            1:       clken = ~clken;
            2:       clken = ($urandom_range(0, 3) != 0);
            default: clken = 1'b1;
        endcase
    endtask

    task automatic step(output bit en);
        next_en();
        @(posedge clock);
        en = clken && !aclr;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bit en;
        repeat (n) step(en);
    endtask

    task automatic beat(input bit f, input bit l, input int s, input int a, input int b);
        bit en;
        int tries;
        tries    = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        sumin    = s[15:0];
        dataa    = a[7:0];
        datab    = b[7:0];
        do begin
            step(en);
            tries++;
        end while (!en && tries < 50);
        if (!en) chk("beat_accept", 0, 1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts enabled edges after the last acceptance until dut d raises out_valid.
    task automatic wait_out(input int d, output int cnt, output bit seen);
        bit en;
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(en);
            if (en) begin
                cnt++;
                if (ov_v[d]) seen = 1'b1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   cnt, pulses;
        bit   seen, en;

        tbl[0] = '{0, -100, -128, -128, 16284, 1'b0};
        tbl[1] = '{1, 32000, 127, 127, 32767, 1'b1};
        tbl[2] = '{2, 32000, 127, 127, -17407, 1'b1};
        tbl[3] = '{1, 5, 2, 3, 11, 1'b0};
        tbl[4] = '{2, 16640, 127, 127, -32767, 1'b1};
        tbl[5] = '{3, 0, 255, 255, 65025, 1'b0};
        tbl[6] = '{1, -32768, -128, 127, -32768, 1'b1};
        tbl[7] = '{2, -32768, -128, 127, 16512, 1'b1};
        tbl[8] = '{3, 65535, 255, 255, 130560, 1'b0};
        tbl[9] = '{0, -1, -1, -1, 0, 1'b0};

        // Reset with clken low must still clear the outputs.
        aclr = 1'b1; clken = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        dataa = '0; datab = '0; sumin = '0;
        repeat (3) @(negedge clock);
        chk("rst_ov", longint'(ov_v), 0);
        chk("rst_ovf", longint'(ovf_v), 0);
        chk("rst_res0", longint'(res0), 0);
        chk("rst_res1", longint'(res1), 0);
        aclr = 1'b0;

        // Three-term frame with exact latency and single-cycle pulse.
        beat(1, 0, 3, 1, 2);
        beat(0, 0, 0, -4, 5);
        beat(0, 1, 0, 7, -1);
        wait_out(0, cnt, seen);
        chk("t1_seen", longint'(seen), 1);
        chk("t1_latency", cnt, 4);
        chk("t1_res", sres(0), -22);
        chk("t1_ovf", longint'(ovf_v[0]), 0);
        step(en);
        chk("t1_pulse_end", longint'(ov_v[0]), 0);
        idle(6);

        for (int i = 0; i < 10; i++) begin
            beat(1, 1, tbl[i].s, tbl[i].a, tbl[i].b);
            wait_out(tbl[i].d, cnt, seen);
            chk($sformatf("tbl%0d_seen", i), longint'(seen), 1);
            chk($sformatf("tbl%0d_res", i), sres(tbl[i].d), tbl[i].res);
            chk($sformatf("tbl%0d_ovf", i), longint'(ovf_v[tbl[i].d]), longint'(tbl[i].ovf));
            idle(3);
        end

        // Back-to-back single-term frames give pulses on consecutive edges.
        beat(1, 1, 0, 1, 1);
        beat(1, 1, 0, 2, 3);
        beat(1, 1, 0, -1, 5);
        wait_out(0, cnt, seen);
        chk("b2b_latency", cnt, 2);
        chk("b2b_res0", sres(0), 1);
        step(en);
        chk("b2b_ov1", longint'(ov_v[0]), 1);
        chk("b2b_res1", sres(0), 6);
        step(en);
        chk("b2b_ov2", longint'(ov_v[0]), 1);
        chk("b2b_res2", sres(0), -5);
        step(en);
        chk("b2b_end", longint'(ov_v[0]), 0);
        idle(6);

        // clken toggling every cycle; latency counted in enabled edges only.
        cmode = 1;
        for (int i = 0; i < 9; i++) beat(i == 0, i == 8, 0, 2, 3);
        wait_out(0, cnt, seen);
        chk("tog_seen", longint'(seen), 1);
        chk("tog_latency", cnt, 4);
        chk("tog_res", sres(0), 54);
        step(en);
        chk("tog_hold_en", longint'(en), 0);
        chk("tog_hold_ov", longint'(ov_v[0]), 1);
        cmode = 0;
        idle(6);

        // A new first abandons the open frame without output.
        beat(1, 0, 0, 1, 1);
        beat(0, 0, 0, 1, 1);
        beat(1, 1, 10, 1, 1);
        wait_out(0, cnt, seen);
        chk("int_latency", cnt, 4);
        chk("int_res", sres(0), 11);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(en);
            if (en && ov_v[0]) pulses++;
        end
        chk("int_extra_pulses", pulses, 0);

        // Reset with the last beat in flight discards the frame.
        beat(1, 0, 0, 3, 3);
        beat(0, 1, 0, 3, 3);
        aclr = 1'b1;
        step(en);
        aclr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(en);
            if (en && ov_v != 4'b0) pulses++;
        end
        chk("rst_mid_pulses", pulses, 0);
        chk("rst_mid_res0", longint'(res0), 0);
        chk("rst_mid_res3", longint'(res3), 0);
        chk("rst_mid_ovf", longint'(ovf_v), 0);
        beat(1, 1, 0, 255, 255);
        wait_out(3, cnt, seen);
        chk("post_rst_seen", longint'(seen), 1);
        chk("post_rst_res", sres(3), 65025);
        idle(4);

        // Random frames with gaps, dropped lasts and random clock enables.
        for (int f = 0; f < 250; f++) begin
            int len;
            bit drop;
            len   = $urandom_range(1, 6);
            drop  = ($urandom_range(0, 9) == 0);
            cmode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 4) == 0) idle(1);
                beat(k == 0, (k == len - 1) && !drop, int'($urandom), int'($urandom), int'($urandom));
            end
        end
        cmode = 0;
        idle(12);
        for (int d = 0; d < 4; d++) chk($sformatf("drain_d%0d", d), mq[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
